// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker: strips F0/E0 prefixes, tracks Shift/Caps Lock and
// emits {shift_eff, make_code} with a one-cycle valid pulse per printable make code.
module ps2_key_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter bit          CAPS_EN        = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx_done_tick,
    input  logic [7:0] i_rx_data,
    output logic [8:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_shift,
    output logic       o_caps_lock
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lshift_q, lshift_d;
    logic            rshift_q, rshift_d;
    logic            caps_q, caps_d;
    logic            caps_held_q, caps_held_d;
    logic            shift_q;
    logic [8:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            shift_eff;
    logic            expired;

    function automatic logic is_letter(input logic [7:0] b);
        case (b)
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: is_letter = 1'b1;
            default: is_letter = 1'b0;
        endcase
    endfunction

    // Stale prefix is abandoned only when no byte arrives in the expiry cycle.
    assign expired = (state_q != StIdle) && (cnt_q == CntMax) && !i_rx_done_tick;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_rx_done_tick) begin
            case (state_q)
                StIdle: begin
                    if (i_rx_data == 8'hF0)      state_d = StBrk;
                    else if (i_rx_data == 8'hE0) state_d = StExt;
                end
                StBrk: begin
                    if (i_rx_data == 8'hF0)      state_d = StBrk;
                    else if (i_rx_data == 8'hE0) state_d = StExtBrk;
                    else                         state_d = StIdle;
                end
                StExt: begin
                    if (i_rx_data == 8'hF0)      state_d = StExtBrk;
                    else if (i_rx_data == 8'hE0) state_d = StExt;
                    else                         state_d = StIdle;
                end
                default: begin
                    if (i_rx_data != 8'hF0 && i_rx_data != 8'hE0) state_d = StIdle;
                end
            endcase
        end else if (expired) begin
            state_d = StIdle;
        end
    end

    assign shift_eff = is_letter(i_rx_data) ? ((lshift_q | rshift_q) ^ caps_q)
                                            : (lshift_q | rshift_q);

    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (i_rx_done_tick || state_q == StIdle || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (i_rx_done_tick) begin
            case (state_q)
                StIdle: begin
                    case (i_rx_data)
                        8'hF0, 8'hE0, 8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        8'h12: lshift_d = 1'b1;
                        8'h59: rshift_d = 1'b1;
                        8'h58: begin
                            if (CAPS_EN && !caps_held_q) begin
                                caps_d      = ~caps_q;
                                caps_held_d = 1'b1;
                            end
                        end
                        default: begin
                            key_valid_d = 1'b1;
                            key_code_d  = {shift_eff, i_rx_data};
                        end
                    endcase
                end
                StBrk: begin
                    case (i_rx_data)
                        8'h12:   lshift_d    = 1'b0;
                        8'h59:   rshift_d    = 1'b0;
                        8'h58:   caps_held_d = 1'b0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q       <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            shift_q     <= 1'b0;
            key_code_q  <= 9'h000;
            key_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            shift_q     <= lshift_d | rshift_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign o_key_code  = key_code_q;
    assign o_key_valid = key_valid_q;
    assign o_shift     = shift_q;
    assign o_caps_lock = caps_q;

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits between the PS/2 byte receiver and the key-code-to-ASCII stage.
- Consumes raw scan-code bytes and strips break (F0) and extended (E0) prefixes.
- Tracks Shift and Caps Lock state.
- Emits a 9-bit key code, {shift_eff, make_code}, with a one-cycle valid pulse for each printable-candidate make code.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: clocks without a byte before a pending prefix is abandoned; counter width = $clog2(TIMEOUT_CYCLES).
- CAPS_EN, 1: 1 = Caps Lock tracked; 0 = Caps Lock codes ignored and o_caps_lock held 0.

Ports:
- i_clk  in  1  system clock; all logic is rising-edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_rx_done_tick  in  1  one-cycle strobe: i_rx_data holds a complete byte.
- i_rx_data  in  8  received scan-code byte.
- o_key_code  out  9  [8] = effective shift, [7:0] = make code; held until next valid.
- o_key_valid  out  1  one-cycle pulse; o_key_code is new this cycle.
- o_shift  out  1  left or right Shift currently held.
- o_caps_lock  out  1  Caps Lock toggle state (LED drive).

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, o_key_code=9'h000, o_key_valid=0, o_shift=0, o_caps_lock=0, lshift=rshift=caps_held=0, timeout counter=0.
- All state updates occur only on cycles with i_rx_done_tick=1, except the timeout.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- IDLE:
  - F0 -> BRK.
  - E0 -> EXT.
  - FA, AA, FE, EE, 00, FF -> ignored, stay IDLE.
  - 12 -> set lshift; 59 -> set rshift.
  - 58 -> if CAPS_EN and !caps_held: toggle caps, set caps_held; else nothing. No output in any of these cases.
  - Any other byte -> o_key_valid=1 next cycle.
- BRK:
  - 12 clears lshift; 59 clears rshift; 58 clears caps_held; any other byte is discarded. Then -> IDLE.
  - F0 -> stay BRK. E0 -> EXT_BRK.
  - No output from BRK.
- EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte discarded (extended keys, including fake shifts E0 12, produce no output and do not change shift) -> IDLE.
- EXT_BRK: any byte other than F0/E0 discarded -> IDLE; F0/E0 -> stay EXT_BRK.
- Effective shift bit:
  - Letter codes (1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A): shift_eff = (lshift|rshift) ^ caps.
  - All other codes: shift_eff = lshift|rshift.
  - Both use the shift/caps values registered before the current byte.
- Latency: o_key_valid and the new o_key_code are registered one clock after the i_rx_done_tick of the make byte. Repeated make bytes (typematic) each produce a pulse.
- o_shift = lshift|rshift, registered. Releasing one shift while the other is held keeps o_shift=1.
- Caps Lock typematic repeats do not re-toggle until the Caps Lock break code (F0 58) is seen.
- Timeout:
  - Counter clears on every i_rx_done_tick and while in IDLE.
  - In BRK, EXT or EXT_BRK, on reaching TIMEOUT_CYCLES-1 without a tick -> IDLE, counter cleared, no output, modifier state unchanged.
  - A tick arriving in the same cycle as expiry wins: the byte is processed in the current state.
- Reset mid-prefix returns to IDLE; the following byte is treated as a fresh code.

Test Plan:
- Reset, then byte 1C -> o_key_valid pulse one cycle after the tick, o_key_code=9'h01C, o_shift=0.
- Bytes 12, 1C, F0 1C, F0 12, 1C -> outputs 9'h11C then 9'h01C. o_shift is 1 between 12 and F0 12. No pulse for 12, F0 1C or F0 12.
- Bytes 58, 58, F0 58, then 1C, 16 -> o_caps_lock=1 (not re-toggled by the second 58), outputs 9'h11C and 9'h016. With 12 also held, 1C -> 9'h01C and 16 -> 9'h116.
- Bytes E0 75, E0 F0 75, E0 12, then 1C -> only pulse is 9'h01C; o_shift stays 0 throughout.
- TIMEOUT_CYCLES=16: byte F0, idle 20 clocks, then 1C -> 9'h01C pulse, since the stale break was dropped. Repeat with 1C arriving 10 clocks after F0 -> no pulse.
- Assert i_reset_n=0 in BRK with shift held, release, send 1C -> 9'h01C; all outputs 0 during reset.
